// File: rtl/wb_fifo_pkg.sv
// Shared definitions for the wb_fifo_slave mailbox: register indices, STATUS/CTRL bit
// positions and a STATUS word packer.
package wb_fifo_pkg;

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_CTRL   = 2'd2,
        REG_RSVD   = 2'd3
    } reg_idx_e;

    localparam int ST_TX_FULL    = 0;
    localparam int ST_TX_EMPTY   = 1;
    localparam int ST_RX_FULL    = 2;
    localparam int ST_RX_EMPTY   = 3;
    localparam int ST_TX_CNT_LSB = 8;
    localparam int ST_RX_CNT_LSB = 16;
    localparam int ST_CNT_W      = 8;

    localparam int CTRL_CLR_TX   = 0;
    localparam int CTRL_CLR_RX   = 1;
    localparam int CTRL_MASK_LSB = 8;
    localparam int CTRL_MASK_W   = 2;
    localparam int MASK_RX_NONEMPTY = 0;
    localparam int MASK_TX_EMPTY    = 1;

    function automatic logic [31:0] status_word(
        input logic                tx_full,
        input logic                tx_empty,
        input logic                rx_full,
        input logic                rx_empty,
        input logic [ST_CNT_W-1:0] tx_cnt,
        input logic [ST_CNT_W-1:0] rx_cnt
    );
        logic [31:0] word;
        word                            = '0;
        word[ST_TX_FULL]                = tx_full;
        word[ST_TX_EMPTY]               = tx_empty;
        word[ST_RX_FULL]                = rx_full;
        word[ST_RX_EMPTY]               = rx_empty;
        word[ST_TX_CNT_LSB +: ST_CNT_W] = tx_cnt;
        word[ST_RX_CNT_LSB +: ST_CNT_W] = rx_cnt;
        return word;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with synchronous clear; push is refused when full and pop
// when empty, regardless of the other operation in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_clr,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_din,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_dout,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_dout    = r_mem[r_rd_ptr];
    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;

    // NOTE: sequential state uses non-blocking assignments so every register samples the
    // pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; occupancy is tracked by the pointers and count,
    // so stale contents are never observable and the array can map onto plain RAM.
    always_ff @(posedge i_clk) begin
        if (w_push_ok && !i_clr) r_mem[r_wr_ptr] <= i_din;
    end

endmodule

// File: rtl/wb_fifo_slave.sv
// Wishbone B4 pipelined mailbox: DATA writes feed the TX FIFO, DATA reads drain the RX FIFO.
// Optional interrupt output enabled with `define WB_FIFO_IRQ_EN.
module wb_fifo_slave
    import wb_fifo_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int TAGSIZE = 1
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               wb_cyc_i,
    input  logic               wb_stb_i,
    input  logic               wb_we_i,
    input  logic [31:0]        wb_adr_i,
    input  logic [31:0]        wb_dat_i,
    input  logic [3:0]         wb_sel_i,
    input  logic [TAGSIZE-1:0] wb_tgd_i,
    output logic [31:0]        wb_dat_o,
    output logic [TAGSIZE-1:0] wb_tgd_o,
    output logic               wb_ack_o,
    output logic               wb_err_o,
    output logic               wb_stall_o,
    output logic [31:0]        tx_data_o,
    output logic               tx_valid_o,
    input  logic               tx_ready_i,
    input  logic [31:0]        rx_data_i,
    input  logic               rx_valid_i,
`ifdef WB_FIFO_IRQ_EN
    output logic               irq_o,
`endif
    output logic               rx_ready_o
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic               w_accept;
    reg_idx_e           w_reg;
    logic               w_err_d;
    logic [31:0]        w_rdata;
    logic [31:0]        w_ctrl_rd;
    logic               w_tx_push, w_tx_pop, w_tx_clr;
    logic               w_rx_push, w_rx_pop, w_rx_clr;
    logic               w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic [CNT_W-1:0]   w_tx_count, w_rx_count;
    logic [31:0]        w_rx_dout;
    logic               w_unused_adr;

    logic               r_ack;
    logic               r_err;
    logic [31:0]        r_dat;
    logic [TAGSIZE-1:0] r_tgd;

    assign w_accept     = wb_cyc_i & wb_stb_i;
    assign w_reg        = reg_idx_e'(wb_adr_i[3:2]);
    assign w_unused_adr = ^{wb_adr_i[31:4], wb_adr_i[1:0]};

    assign w_tx_pop   = tx_valid_o & tx_ready_i;
    assign w_rx_push  = rx_valid_i & rx_ready_o;
    assign tx_valid_o = ~w_tx_empty;
    assign rx_ready_o = ~w_rx_full;

    sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_tx_fifo (
        .i_clk   (clk_i),
        .i_rst_n (rstn_i),
        .i_clr   (w_tx_clr),
        .i_push  (w_tx_push),
        .i_din   (wb_dat_i),
        .i_pop   (w_tx_pop),
        .o_dout  (tx_data_o),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty),
        .o_count (w_tx_count)
    );

    sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_rx_fifo (
        .i_clk   (clk_i),
        .i_rst_n (rstn_i),
        .i_clr   (w_rx_clr),
        .i_push  (w_rx_push),
        .i_din   (rx_data_i),
        .i_pop   (w_rx_pop),
        .o_dout  (w_rx_dout),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty),
        .o_count (w_rx_count)
    );

`ifdef WB_FIFO_IRQ_EN
    logic [CTRL_MASK_W-1:0] r_mask;
    logic                   r_irq;
    logic [CTRL_MASK_W-1:0] w_irq_src;

    assign w_irq_src[MASK_RX_NONEMPTY] = (w_rx_count != '0);
    assign w_irq_src[MASK_TX_EMPTY]    = w_tx_empty;
    assign irq_o     = r_irq;
    assign w_ctrl_rd = 32'(r_mask) << CTRL_MASK_LSB;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_mask <= '0;
            r_irq  <= 1'b0;
        end else begin
            if (w_accept && wb_we_i && w_reg == REG_CTRL)
                r_mask <= wb_dat_i[CTRL_MASK_LSB +: CTRL_MASK_W];
            r_irq <= |(w_irq_src & r_mask);
        end
    end
`else
    assign w_ctrl_rd = '0;
`endif

    // NOTE: every signal assigned below gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        w_err_d   = 1'b0;
        w_rdata   = '0;
        w_tx_push = 1'b0;
        w_rx_pop  = 1'b0;
        w_tx_clr  = 1'b0;
        w_rx_clr  = 1'b0;
        if (w_accept) begin
            case (w_reg)
                REG_DATA: begin
                    if (wb_we_i) begin
                        if (wb_sel_i == 4'hF && !w_tx_full) w_tx_push = 1'b1;
                        else                                 w_err_d   = 1'b1;
                    end else if (!w_rx_empty) begin
                        w_rx_pop = 1'b1;
                        w_rdata  = w_rx_dout;
                    end else begin
                        w_err_d = 1'b1;
                    end
                end
                REG_STATUS: begin
                    if (wb_we_i) w_err_d = 1'b1;
                    else w_rdata = status_word(w_tx_full, w_tx_empty, w_rx_full, w_rx_empty,
                                               ST_CNT_W'(w_tx_count), ST_CNT_W'(w_rx_count));
                end
                REG_CTRL: begin
                    if (wb_we_i) begin
                        w_tx_clr = wb_dat_i[CTRL_CLR_TX];
                        w_rx_clr = wb_dat_i[CTRL_CLR_RX];
                    end else begin
                        w_rdata = w_ctrl_rd;
                    end
                end
                default: w_err_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            r_dat <= '0;
            r_tgd <= '0;
        end else begin
            r_ack <= w_accept & ~w_err_d;
            r_err <= w_accept & w_err_d;
            r_dat <= w_rdata;
            if (w_accept) r_tgd <= wb_tgd_i;
        end
    end

    // A master that has dropped cyc no longer owns the bus, so its response is suppressed.
    assign wb_ack_o   = r_ack & wb_cyc_i;
    assign wb_err_o   = r_err & wb_cyc_i;
    assign wb_dat_o   = r_dat;
    assign wb_tgd_o   = r_tgd;
    assign wb_stall_o = 1'b0;

endmodule

// File: tb/tb_wb_fifo_slave.sv
// Directed self-checking bench for wb_fifo_slave (DEPTH=16, TAGSIZE=1); covers the
// irq_o behaviour too when built with WB_FIFO_IRQ_EN.
module tb_wb_fifo_slave;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        wb_cyc_i, wb_stb_i, wb_we_i;
    logic [31:0] wb_adr_i, wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic [0:0]  wb_tgd_i;
    logic [31:0] wb_dat_o;
    logic [0:0]  wb_tgd_o;
    logic        wb_ack_o, wb_err_o, wb_stall_o;
    logic [31:0] tx_data_o;
    logic        tx_valid_o, tx_ready_i;
    logic [31:0] rx_data_i;
    logic        rx_valid_i, rx_ready_o;
`ifdef WB_FIFO_IRQ_EN
    logic        irq_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic        r_ack, r_err;
    logic [31:0] r_dat;
    logic [0:0]  r_tag;

    wb_fifo_slave #(.DEPTH(16), .TAGSIZE(1)) dut (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .wb_cyc_i   (wb_cyc_i),
        .wb_stb_i   (wb_stb_i),
        .wb_we_i    (wb_we_i),
        .wb_adr_i   (wb_adr_i),
        .wb_dat_i   (wb_dat_i),
        .wb_sel_i   (wb_sel_i),
        .wb_tgd_i   (wb_tgd_i),
        .wb_dat_o   (wb_dat_o),
        .wb_tgd_o   (wb_tgd_o),
        .wb_ack_o   (wb_ack_o),
        .wb_err_o   (wb_err_o),
        .wb_stall_o (wb_stall_o),
        .tx_data_o  (tx_data_o),
        .tx_valid_o (tx_valid_o),
        .tx_ready_i (tx_ready_i),
        .rx_data_i  (rx_data_i),
        .rx_valid_i (rx_valid_i),
`ifdef WB_FIFO_IRQ_EN
        .irq_o      (irq_o),
`endif
        .rx_ready_o (rx_ready_o)
    );

    always #5 clk_i = ~clk_i;

    // Single transfer: request in one cycle, response sampled 1 time unit after the next edge.
    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic [0:0] tag);
        @(posedge clk_i); #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = adr;  wb_dat_i = dat;  wb_sel_i = sel; wb_tgd_i = tag;
        @(posedge clk_i); #1;
        r_ack = wb_ack_o; r_err = wb_err_o; r_dat = wb_dat_o; r_tag = wb_tgd_o;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++; if (wb_ack_o !== 1'b0)   begin n_fail++; $display("FAIL reset_ack: got %b exp 0", wb_ack_o); end
        n_checks++; if (wb_err_o !== 1'b0)   begin n_fail++; $display("FAIL reset_err: got %b exp 0", wb_err_o); end
        n_checks++; if (wb_dat_o !== 32'h0)  begin n_fail++; $display("FAIL reset_dat: got %h exp 0", wb_dat_o); end
        n_checks++; if (wb_tgd_o !== 1'b0)   begin n_fail++; $display("FAIL reset_tgd: got %b exp 0", wb_tgd_o); end
        n_checks++; if (tx_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b exp 0", tx_valid_o); end
        n_checks++; if (rx_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_rx_ready: got %b exp 1", rx_ready_o); end
        n_checks++; if (wb_stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b exp 0", wb_stall_o); end
        wb_xfer(1'b0, 32'h4, 32'h0, 4'hF, 1'b0);
        n_checks++; if (r_dat !== 32'h0000000A) begin n_fail++; $display("FAIL reset_status: got %h exp 0000000a", r_dat); end
    endtask

    task automatic test_tx_write();
        wb_xfer(1'b1, 32'h0, 32'hCAFE0001, 4'hF, 1'b1);
        n_checks++; if ({r_ack, r_err} !== 2'b10) begin n_fail++; $display("FAIL txw_ack_err: got %b exp 10", {r_ack, r_err}); end
        n_checks++; if (r_tag !== 1'b1) begin n_fail++; $display("FAIL txw_tag: got %b exp 1", r_tag); end
        n_checks++; if (tx_valid_o !== 1'b1) begin n_fail++; $display("FAIL txw_valid: got %b exp 1", tx_valid_o); end
        n_checks++; if (tx_data_o !== 32'hCAFE0001) begin n_fail++; $display("FAIL txw_data: got %h exp cafe0001", tx_data_o); end
        wb_xfer(1'b0, 32'h4, 32'h0, 4'hF, 1'b0);
        n_checks++; if (r_dat[15:8] !== 8'd1) begin n_fail++; $display("FAIL txw_count: got %0d exp 1", r_dat[15:8]); end
    endtask

    task automatic test_bad_sel();
        wb_xfer(1'b1, 32'h0, 32'h12345678, 4'h3, 1'b0);
        n_checks++; if ({r_ack, r_err} !== 2'b01) begin n_fail++; $display("FAIL badsel_err: got %b exp 01", {r_ack, r_err}); end
        wb_xfer(1'b0, 32'h4, 32'h0, 4'hF, 1'b0);
        n_checks++; if (r_dat[15:8] !== 8'd1) begin n_fail++; $display("FAIL badsel_count: got %0d exp 1", r_dat[15:8]); end
    endtask

    task automatic test_ctrl_clear();
        wb_xfer(1'b1, 32'h8, 32'h1, 4'hF, 1'b0);
        n_checks++; if (r_ack !== 1'b1) begin n_fail++; $display("FAIL clr_ack: got %b exp 1", r_ack); end
        n_checks++; if (tx_valid_o !== 1'b0) begin n_fail++; $display("FAIL clr_valid: got %b exp 0", tx_valid_o); end
    endtask

    task automatic test_cyc_drop();
        @(posedge clk_i); #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_adr_i = 32'h0; wb_dat_i = 32'h0000D00D; wb_sel_i = 4'hF;
        @(posedge clk_i); #1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        #1;
        n_checks++; if ({wb_ack_o, wb_err_o} !== 2'b00) begin n_fail++; $display("FAIL drop_resp: got %b exp 00", {wb_ack_o, wb_err_o}); end
        n_checks++; if (tx_data_o !== 32'h0000D00D) begin n_fail++; $display("FAIL drop_side_effect: got %h exp 0000d00d", tx_data_o); end
        wb_xfer(1'b1, 32'h8, 32'h1, 4'hF, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic exp_ack;
        @(posedge clk_i); #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_adr_i = 32'h0; wb_sel_i = 4'hF; wb_dat_i = 32'h100;
        for (int i = 0; i < 17; i++) begin
            @(posedge clk_i); #1;
            exp_ack = (i < 16);
            n_checks++;
            if ({wb_ack_o, wb_err_o} !== {exp_ack, ~exp_ack})
                begin n_fail++; $display("FAIL b2b_resp[%0d]: got %b exp %b", i, {wb_ack_o, wb_err_o}, {exp_ack, ~exp_ack}); end
            wb_dat_i = 32'h100 + 32'(i + 1);
            if (i == 16) begin wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; end
        end
        n_checks++; if (tx_data_o !== 32'h100) begin n_fail++; $display("FAIL b2b_head: got %h exp 00000100", tx_data_o); end
        wb_xfer(1'b0, 32'h4, 32'h0, 4'hF, 1'b0);
        n_checks++; if (r_dat !== 32'h00001009) begin n_fail++; $display("FAIL b2b_status: got %h exp 00001009", r_dat); end
    endtask

    task automatic test_clear_with_pop();
        @(posedge clk_i); #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_adr_i = 32'h8; wb_dat_i = 32'h1; wb_sel_i = 4'hF; tx_ready_i = 1'b1;
        @(posedge clk_i); #1;
        n_checks++; if (wb_ack_o !== 1'b1) begin n_fail++; $display("FAIL clrpop_ack: got %b exp 1", wb_ack_o); end
        n_checks++; if (tx_valid_o !== 1'b0) begin n_fail++; $display("FAIL clrpop_valid: got %b exp 0", tx_valid_o); end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; tx_ready_i = 1'b0;
        wb_xfer(1'b0, 32'h4, 32'h0, 4'hF, 1'b0);
        n_checks++; if (r_dat[15:8] !== 8'd0) begin n_fail++; $display("FAIL clrpop_count: got %0d exp 0", r_dat[15:8]); end
    endtask

    task automatic test_rx_read();
        logic [31:0] words [3];
        words[0] = 32'hA0000001; words[1] = 32'hB0000002; words[2] = 32'hC0000003;
        @(posedge clk_i); #1;
        for (int i = 0; i < 3; i++) begin
            rx_valid_i = 1'b1; rx_data_i = words[i];
            @(posedge clk_i); #1;
        end
        rx_valid_i = 1'b0;
        wb_xfer(1'b0, 32'h4, 32'h0, 4'hF, 1'b0);
        n_checks++; if (r_dat[23:16] !== 8'd3) begin n_fail++; $display("FAIL rx_count: got %0d exp 3", r_dat[23:16]); end
        @(posedge clk_i); #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_i); #1;
            if (i < 3) begin
                n_checks++; if ({wb_ack_o, wb_err_o} !== 2'b10) begin n_fail++; $display("FAIL rx_resp[%0d]: got %b exp 10", i, {wb_ack_o, wb_err_o}); end
                n_checks++; if (wb_dat_o !== words[i]) begin n_fail++; $display("FAIL rx_data[%0d]: got %h exp %h", i, wb_dat_o, words[i]); end
            end else begin
                n_checks++; if ({wb_ack_o, wb_err_o} !== 2'b01) begin n_fail++; $display("FAIL rx_empty_resp: got %b exp 01", {wb_ack_o, wb_err_o}); end
                n_checks++; if (wb_dat_o !== 32'h0) begin n_fail++; $display("FAIL rx_empty_data: got %h exp 0", wb_dat_o); end
                wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
            end
        end
    endtask

    task automatic test_bad_addr();
        wb_xfer(1'b0, 32'hC, 32'h0, 4'hF, 1'b0);
        n_checks++; if ({r_ack, r_err} !== 2'b01) begin n_fail++; $display("FAIL rsvd_err: got %b exp 01", {r_ack, r_err}); end
        wb_xfer(1'b1, 32'h4, 32'hFFFFFFFF, 4'hF, 1'b0);
        n_checks++; if ({r_ack, r_err} !== 2'b01) begin n_fail++; $display("FAIL status_wr_err: got %b exp 01", {r_ack, r_err}); end
        wb_xfer(1'b0, 32'h8, 32'h0, 4'hF, 1'b0);
        n_checks++; if ({r_ack, r_dat} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL ctrl_read: got %b/%h exp 1/0", r_ack, r_dat); end
    endtask

`ifdef WB_FIFO_IRQ_EN
    task automatic test_irq();
        wb_xfer(1'b1, 32'h8, 32'h100, 4'hF, 1'b0);
        @(posedge clk_i); #1;
        n_checks++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL irq_idle: got %b exp 0", irq_o); end
        rx_valid_i = 1'b1; rx_data_i = 32'h5A5A5A5A;
        @(posedge clk_i); #1;
        rx_valid_i = 1'b0;
        n_checks++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL irq_early: got %b exp 0", irq_o); end
        @(posedge clk_i); #1;
        n_checks++; if (irq_o !== 1'b1) begin n_fail++; $display("FAIL irq_set: got %b exp 1", irq_o); end
        wb_xfer(1'b0, 32'h8, 32'h0, 4'hF, 1'b0);
        n_checks++; if (r_dat !== 32'h100) begin n_fail++; $display("FAIL irq_mask_read: got %h exp 00000100", r_dat); end
        wb_xfer(1'b0, 32'h0, 32'h0, 4'hF, 1'b0);
        @(posedge clk_i); #1;
        n_checks++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL irq_clear: got %b exp 0", irq_o); end
        wb_xfer(1'b1, 32'h8, 32'h0, 4'hF, 1'b0);
    endtask
`endif

    task automatic test_reset_mid();
        @(posedge clk_i); #1;
        rx_valid_i = 1'b1; rx_data_i = 32'h77777777;
        @(posedge clk_i); #1;
        rx_valid_i = 1'b0;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h0;
        @(negedge clk_i);
        rstn_i = 1'b0;
        @(posedge clk_i); #1;
        n_checks++; if ({wb_ack_o, wb_err_o} !== 2'b00) begin n_fail++; $display("FAIL rstmid_resp: got %b exp 00", {wb_ack_o, wb_err_o}); end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        @(negedge clk_i);
        rstn_i = 1'b1;
        wb_xfer(1'b0, 32'h4, 32'h0, 4'hF, 1'b0);
        n_checks++; if (r_dat !== 32'h0000000A) begin n_fail++; $display("FAIL rstmid_status: got %h exp 0000000a", r_dat); end
    endtask

    initial begin
        rstn_i = 1'b0;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0; wb_tgd_i = '0;
        tx_ready_i = 1'b0; rx_data_i = '0; rx_valid_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rstn_i = 1'b1;
        test_reset();
        test_tx_write();
        test_bad_sel();
        test_ctrl_clear();
        test_cyc_drop();
        test_back_to_back();
        test_clear_with_pop();
        test_rx_read();
        test_bad_addr();
`ifdef WB_FIFO_IRQ_EN
        test_irq();
`endif
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
